board_ctrl_unit: RTL
====================

Name: board_ctrl_unit

Overview:
- Board-level control front end. Turns raw slide switches and a step button into clean CPU control signals.
- Replaces the derived-clock scheme with a single-clock design. The CPU advances on a one-cycle clock-enable, `cpu_en`; no generated clocks.
- Adds per-bit switch debouncing, a parametrised speed ladder, and single-step while paused.
- Sits between the board I/O and the pipeline CPU top and display mux.

Parameters:
- SW_WIDTH, 16: number of slide switches. Must be ≥ ADDR_BITS+4.
- ADDR_BITS, 12: RAM byte-address width. Display address is ADDR_BITS-2 bits.
- N_SPEEDS, 4: number of speed settings (≥2).
- BASE_DIV, 10_000_000: clk cycles per CPU step at speed 0. Must be ≥ 2^(N_SPEEDS-1).
- DEB_CYCLES, 16: consecutive cycles an input must differ from its debounced value before it is accepted (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SW  in  SW_WIDTH  raw slide switches (asynchronous)
- btn_step  in  1  raw single-step push button (asynchronous)
- cpu_en  out  1  one-cycle CPU clock-enable pulse
- go  out  1  debounced SW[0]; 1 = run, 0 = pause
- rst  out  1  debounced SW[1]; 1 = CPU synchronous reset
- speed_sel  out  clog2(N_SPEEDS)  current speed index
- display_op  out  3  debounced SW[5:3]
- ram_display_addr  out  ADDR_BITS-2  debounced SW[ADDR_BITS+3:6]

Behaviour:
- **Reset (rst_n=0, async):**
  - All sync flops, debounced values, debounce counters, divider counter and speed_sel go to 0.
  - cpu_en, go, rst, display_op, ram_display_addr all 0.
- **Input sync:** every SW bit and btn_step passes through a 2-flop synchronizer.
- **Debounce (per bit, independent):**
  - Counter increments each cycle while synchronized value ≠ debounced value.
  - Counter clears the first cycle they are equal.
  - Debounced value takes the synchronized value on the DEB_CYCLES-th consecutive differing edge; counter clears at the same time.
  - A clean input change therefore appears on the output DEB_CYCLES+2 edges later.
  - Glitches shorter than DEB_CYCLES cycles are never seen.
- **Edge detect:** one-cycle rising-edge pulses from debounced SW[2] (spd_up) and debounced btn_step (step).
- **Speed ladder:**
  - On spd_up, speed_sel ← speed_sel+1; it wraps from N_SPEEDS-1 to 0.
  - Divide period P = BASE_DIV >> speed_sel, i.e. each step halves the period.
- **Divider:**
  - Counter runs 0..P-1 while go=1 and rst=0.
  - tick = (cnt == P-1); the counter wraps to 0 on the same edge.
  - Counter is held at 0 while go=0 or rst=1.
  - On spd_up the counter clears to 0 and no tick is issued that cycle. spd_up has priority over a terminal count in the same cycle.
- **cpu_en (registered, 1-cycle latency from the cause):**
  - rst=1: cpu_en = 0.
  - else go=1: cpu_en = tick. step is ignored while running.
  - else go=0: cpu_en = step, exactly one pulse per debounced button press.
  - cpu_en is never high two consecutive cycles unless P=1 while running. At P=1, cpu_en is continuously high.
- **Pass-through fields:** go, rst, display_op, ram_display_addr are the debounced bits, driven directly from their debounced flops.
- **Reset mid-operation:** rst_n assertion clears everything within the same instant. After release, speed returns to 0 and the first tick comes a full BASE_DIV cycles after go is seen high.
- **go falling in the same cycle as a terminal count:** the tick is suppressed, because the counter is held.

Test Plan:
(bench parameters: BASE_DIV=8, N_SPEEDS=4, DEB_CYCLES=4, ADDR_BITS=12)
- Assert rst_n=0 mid-run with SW=16'hFFFF -> all outputs 0 immediately; after release with SW unchanged, go/rst/display_op=3'b111/ram_display_addr=10'h3FF appear after 6 edges, speed_sel=0.
- SW[0]=1, SW[1]=0 clean -> cpu_en pulses every 8 cycles. Toggle SW[2] 0→1 four times, held ≥6 cycles each -> period goes 4, 2, 1 (cpu_en constantly high), then back to 8 with speed_sel=0.
- SW[3] pulses high for 3 cycles, repeated with 1-cycle gaps -> display_op[0] stays 0. Hold SW[3] high 10 cycles -> display_op[0]=1 after exactly 6 edges.
- go=0, press btn_step (held 10 cycles) -> exactly one cpu_en pulse. Press with go=1 -> no extra pulse beyond the divider ticks.
- go=1, raise SW[1] -> rst=1 and cpu_en stays 0. Drop SW[1] -> first cpu_en exactly 8 cycles after rst falls.
- spd_up in the same cycle the counter is at 7 -> no cpu_en that cycle; next cpu_en 4 cycles later.

Source files
------------

// File: rtl/board_ctrl_unit.sv
// ----------------------------------------------------------------------------
// board_ctrl_unit
//   Board-level control front end. Synchronizes and debounces the raw slide
//   switches and step button, then derives a single-clock CPU clock-enable
//   (cpu_en) from a speed-selectable divider (run mode) or the step button
//   (pause mode).
//
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   SW               in   raw slide switches (asynchronous)
//   btn_step         in   raw single-step button (asynchronous)
//   cpu_en           out  one-cycle CPU clock-enable pulse
//   go               out  debounced SW[0]  (1 = run, 0 = pause)
//   rst              out  debounced SW[1]  (CPU synchronous reset)
//   speed_sel        out  current speed index
//   display_op       out  debounced SW[5:3]
//   ram_display_addr out  debounced SW[ADDR_BITS+3:6]
// ----------------------------------------------------------------------------
module board_ctrl_unit #(
    parameter int SW_WIDTH   = 16,
    parameter int ADDR_BITS  = 12,
    parameter int N_SPEEDS   = 4,
    parameter int BASE_DIV   = 10_000_000,
    parameter int DEB_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SW_WIDTH-1:0]         SW,
    input  logic                        btn_step,
    output logic                        cpu_en,
    output logic                        go,
    output logic                        rst,
    output logic [$clog2(N_SPEEDS)-1:0] speed_sel,
    output logic [2:0]                  display_op,
    output logic [ADDR_BITS-3:0]        ram_display_addr
);

    // Only the switches that feed an output are conditioned; the step
    // button rides along as the top bit of the same vector.
    localparam int NB   = ADDR_BITS + 5;
    localparam int BTN  = NB - 1;
    localparam int DCW  = $clog2(DEB_CYCLES + 1);
    localparam int SPW  = $clog2(N_SPEEDS);
    localparam int CW   = $clog2(BASE_DIV + 1);

    logic [NB-1:0]  w_raw;
    logic [NB-1:0]  r_sync1;
    logic [NB-1:0]  r_sync2;
    logic [NB-1:0]  w_deb;

    assign w_raw = {btn_step, SW[ADDR_BITS+3:0]};

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: the synchronized value must disagree with the
    // debounced value for DEB_CYCLES consecutive edges to be accepted.
    // Any single agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NB; i++) begin : g_deb
        logic [DCW-1:0] r_cnt;
        logic           r_val;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_val <= 1'b0;
            end else if (r_sync2[i] == r_val) begin
                r_cnt <= '0;
            end else if (r_cnt == DCW'(DEB_CYCLES - 1)) begin
                r_cnt <= '0;
                r_val <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + DCW'(1);
            end
        end

        assign w_deb[i] = r_val;
    end

    assign go               = w_deb[0];
    assign rst              = w_deb[1];
    assign display_op       = w_deb[5:3];
    assign ram_display_addr = w_deb[ADDR_BITS+3:6];

    // ------------------------------------------------------------------
    // Rising-edge detect on debounced speed-up switch and step button
    // ------------------------------------------------------------------
    logic r_spd_prev;
    logic r_step_prev;
    logic w_spd_up;
    logic w_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spd_prev  <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_spd_prev  <= w_deb[2];
            r_step_prev <= w_deb[BTN];
        end
    end

    assign w_spd_up = w_deb[2]   & ~r_spd_prev;
    assign w_step   = w_deb[BTN] & ~r_step_prev;

    // ------------------------------------------------------------------
    // Speed ladder: each step halves the divide period, wrapping to 0.
    // ------------------------------------------------------------------
    logic [SPW-1:0] r_speed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed <= '0;
        end else if (w_spd_up) begin
            r_speed <= (r_speed == SPW'(N_SPEEDS - 1)) ? '0 : r_speed + SPW'(1);
        end
    end

    assign speed_sel = r_speed;

    // ------------------------------------------------------------------
    // Divider. A speed change restarts the count so the new period is
    // measured from a clean origin; it also outranks a terminal count.
    // ------------------------------------------------------------------
    logic [CW-1:0] r_div;
    logic [CW-1:0] w_period;
    logic [CW-1:0] w_last;
    logic          w_run;
    logic          w_tick;

    assign w_period = CW'(BASE_DIV >> r_speed);
    assign w_last   = w_period - CW'(1);
    assign w_run    = go & ~rst;
    assign w_tick   = w_run & ~w_spd_up & (r_div == w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_spd_up || !w_run || (r_div == w_last)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // CPU clock-enable: divider tick while running, button step while
    // paused, nothing while the CPU is held in reset.
    // ------------------------------------------------------------------
    logic r_cpu_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_en <= 1'b0;
        end else if (rst) begin
            r_cpu_en <= 1'b0;
        end else if (go) begin
            r_cpu_en <= w_tick;
        end else begin
            r_cpu_en <= w_step;
        end
    end

    assign cpu_en = r_cpu_en;

endmodule
